// File: rtl/core_mem_responder_if.sv
// Core-to-responder memory bus. The core (master) raises mem_req with address,
// direction and write data; the responder answers with a one-cycle mem_ready.
interface core_mem_responder_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 24
) ();
   // Handshake: mem_req is sampled only while the responder is idle and is not
   // queued; mem_ready pulses for exactly one cycle, and mem_out/mem_err are
   // meaningful only while mem_ready is high (mem_out keeps its last read value).
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_out;
   logic              mem_ready;
   logic              mem_err;

   modport master (
      output mem_addr, mem_req, mem_we, mem_wdata,
      input  mem_out, mem_ready, mem_err
   );

   modport slave (
      input  mem_addr, mem_req, mem_we, mem_wdata,
      output mem_out, mem_ready, mem_err
   );
endinterface

// File: rtl/core_mem_responder.sv
// Memory responder: word RAM plus a servo/IR register window, answering each
// request with a fixed-latency one-cycle mem_ready pulse.
module core_mem_responder #(
   parameter int                ADDR_W      = 24,
   parameter int                DATA_W      = 24,
   parameter int                RAM_DEPTH   = 256,
   parameter logic [ADDR_W-1:0] IO_BASE     = 24'hFFFF00,
   parameter int                WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                rst,
   core_mem_responder_if.slave bus,
   input  logic [7:0]          servo_in,
   input  logic [7:0]          ir_in,
   output logic [7:0]          servo_out,
   output logic [7:0]          ir_out,
   output logic [1:0]          dbg_state
);
   localparam int                IDX_W     = $clog2(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] RAM_END   = ADDR_W'(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] A_SERVO   = IO_BASE;
   localparam logic [ADDR_W-1:0] A_IR      = IO_BASE + ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_SERVO_I = IO_BASE + ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_IR_I    = IO_BASE + ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_COUNT   = IO_BASE + ADDR_W'(4);
   localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] cap_addr;
   logic              cap_we;
   logic [DATA_W-1:0] cap_wdata;
   logic [DATA_W-1:0] ram [RAM_DEPTH];

   logic [7:0]        servo_s1, servo_s2, ir_s1, ir_s2, ir_prev;
   logic [23:0]       ir_count;

   logic [ADDR_W-1:0] dec_addr;
   logic              dec_we;
   logic              enter_resp;
   logic              commit;
   logic              count_clr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_err;

   assign dbg_state = state;

   // With zero wait states RESP is entered straight from IDLE, so decode must
   // look at the live bus there and at the captured request everywhere else.
   assign dec_addr   = (state == S_IDLE) ? bus.mem_addr : cap_addr;
   assign dec_we     = (state == S_IDLE) ? bus.mem_we   : cap_we;
   assign enter_resp = ((state == S_IDLE) && bus.mem_req && (WAIT_STATES == 0)) ||
                       ((state == S_WAIT) && (wait_cnt == 4'd0));
   assign commit     = (state == S_RESP) && cap_we;
   assign count_clr  = commit && (cap_addr == A_COUNT);

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (dec_addr < RAM_END) begin
         rd_data = ram[dec_addr[IDX_W-1:0]];
      end else begin
         case (dec_addr)
            A_SERVO:   rd_data = DATA_W'(servo_out);
            A_IR:      rd_data = DATA_W'(ir_out);
            A_SERVO_I: rd_data = DATA_W'(servo_s2);
            A_IR_I:    rd_data = DATA_W'(ir_s2);
            A_COUNT:   rd_data = DATA_W'(ir_count);
            default:   rd_err  = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         wait_cnt      <= 4'd0;
         cap_addr      <= '0;
         cap_we        <= 1'b0;
         cap_wdata     <= '0;
         bus.mem_ready <= 1'b0;
         bus.mem_err   <= 1'b0;
         bus.mem_out   <= '0;
         servo_out     <= 8'h00;
         ir_out        <= 8'h00;
      end else begin
         if (enter_resp) begin
            bus.mem_ready <= 1'b1;
            bus.mem_err   <= rd_err;
            if (!dec_we) bus.mem_out <= rd_data;
         end
         case (state)
            S_IDLE: begin
               if (bus.mem_req) begin
                  cap_addr  <= bus.mem_addr;
                  cap_we    <= bus.mem_we;
                  cap_wdata <= bus.mem_wdata;
                  wait_cnt  <= WAIT_INIT;
                  state     <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) state <= S_RESP;
               else wait_cnt <= wait_cnt - 4'd1;
            end
            S_RESP: begin
               bus.mem_ready <= 1'b0;
               bus.mem_err   <= 1'b0;
               state         <= S_IDLE;
               if (commit && (cap_addr == A_SERVO)) servo_out <= cap_wdata[7:0];
               if (commit && (cap_addr == A_IR))    ir_out    <= cap_wdata[7:0];
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // RAM is deliberately left out of reset; a reset mid-transaction blocks the commit.
   always_ff @(posedge clk) begin
      if (!rst && commit && (cap_addr < RAM_END)) ram[cap_addr[IDX_W-1:0]] <= cap_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         servo_s1 <= 8'h00;
         servo_s2 <= 8'h00;
         ir_s1    <= 8'h00;
         ir_s2    <= 8'h00;
         ir_prev  <= 8'h00;
         ir_count <= 24'h0;
      end else begin
         servo_s1 <= servo_in;
         servo_s2 <= servo_s1;
         ir_s1    <= ir_in;
         ir_s2    <= ir_s1;
         ir_prev  <= ir_s2;
         // A clearing write beats a simultaneous change event.
         if (count_clr) ir_count <= 24'h0;
         else if ((ir_s2 != ir_prev) && (ir_count != 24'hFFFFFF)) ir_count <= ir_count + 24'h1;
      end
   end
endmodule
